// File: rtl/uart_work_controller_if.sv
// Bundle of the UART-facing and hash-core-facing signals of uart_work_controller.
// master: the controller itself. slave: the UART/hash-core side (or a bench).
interface uart_work_controller_if #(
    parameter int WORK_BYTES = 44
);
    logic                      rx_rdy;
    logic [7:0]                rx_data;
    logic                      rx_rdy_clr;
    logic [7:0]                tx_din;
    logic                      tx_wr_en;
    logic                      tx_busy;
    logic [WORK_BYTES*8-1:0]   work_data;
    logic                      work_valid;
    logic [31:0]               nonce;
    logic                      nonce_valid;
    logic                      nonce_drop;
    logic                      rx_timeout;

    modport master (
        input  rx_rdy, rx_data, tx_busy, nonce, nonce_valid,
        output rx_rdy_clr, tx_din, tx_wr_en, work_data, work_valid, nonce_drop, rx_timeout
    );

    modport slave (
        output rx_rdy, rx_data, tx_busy, nonce, nonce_valid,
        input  rx_rdy_clr, tx_din, tx_wr_en, work_data, work_valid, nonce_drop, rx_timeout
    );
endinterface

// File: rtl/uart_work_controller.sv
// uart_work_controller: shares one UART between work download and nonce upload.
//  RX: assembles WORK_BYTES bytes (first byte ends in the MSBs) into a shadowed
//      work word and pulses work_valid when a full packet has arrived.
//  TX: sends each accepted 32-bit nonce as 4 bytes, MSB first.
// Optional feature: define UART_CTRL_TIMEOUT_EN to discard a partial packet after
// TIMEOUT_CYCLES idle clocks (rx_timeout pulses); otherwise rx_timeout is always 0.
module uart_work_controller #(
    parameter int WORK_BYTES     = 44,
    parameter int TIMEOUT_CYCLES = 5_000_000
) (
    input  logic                   clk_50m,
    input  logic                   rst,
    uart_work_controller_if.master bus
);
    localparam int              WW         = WORK_BYTES * 8;
    localparam int              CW         = $clog2(WORK_BYTES + 1);
    localparam logic [CW-1:0]   FULL_COUNT = CW'(WORK_BYTES);

    typedef enum logic [1:0] {RX_IDLE, RX_ACK, RX_WAIT} rx_state_t;
    typedef enum logic [1:0] {TX_IDLE, TX_LOAD, TX_START, TX_BUSY} tx_state_t;

    // Selects byte i of a nonce, index 0 being the most significant byte.
    function automatic logic [7:0] nonce_byte(input logic [31:0] n, input logic [1:0] i);
        logic [7:0] b;
        case (i)
            2'd0:    b = n[31:24];
            2'd1:    b = n[23:16];
            2'd2:    b = n[15:8];
            2'd3:    b = n[7:0];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    rx_state_t        rx_state_r, rx_state_s;
    logic [CW-1:0]    count_r;
    logic [WW-1:0]    asm_r;
    logic [WW-1:0]    work_data_r;
    logic             work_valid_r, rx_rdy_clr_r, rx_timeout_r;
    logic             capture_s, pkt_done_s, timeout_hit_s;

    tx_state_t        tx_state_r, tx_state_s;
    logic [31:0]      nonce_r;
    logic [1:0]       idx_r;
    logic [7:0]       tx_din_r;
    logic             tx_wr_en_r, nonce_drop_r;
    logic             latch_s, emit_s, advance_s, drop_s;

    assign bus.rx_rdy_clr = rx_rdy_clr_r;
    assign bus.work_data  = work_data_r;
    assign bus.work_valid = work_valid_r;
    assign bus.rx_timeout = rx_timeout_r;
    assign bus.tx_din     = tx_din_r;
    assign bus.tx_wr_en   = tx_wr_en_r;
    assign bus.nonce_drop = nonce_drop_r;

    // RX next state: capture in idle, acknowledge once, then wait for rdy to drop.
    always_comb begin
        rx_state_s = rx_state_r;
        capture_s  = 1'b0;
        pkt_done_s = 1'b0;
        case (rx_state_r)
            RX_IDLE: begin
                if (bus.rx_rdy) begin
                    capture_s  = 1'b1;
                    rx_state_s = RX_ACK;
                end else begin
                    rx_state_s = RX_IDLE;
                end
            end
            RX_ACK: begin
                rx_state_s = RX_WAIT;
                if (count_r == FULL_COUNT) begin
                    pkt_done_s = 1'b1;
                end else begin
                    pkt_done_s = 1'b0;
                end
            end
            RX_WAIT: begin
                if (!bus.rx_rdy) begin
                    rx_state_s = RX_IDLE;
                end else begin
                    rx_state_s = RX_WAIT;
                end
            end
            default: rx_state_s = RX_IDLE;
        endcase
    end

`ifdef UART_CTRL_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] idle_cnt_r;

    // Timeout fires on the TIMEOUT_CYCLES-th idle clock of a partial packet.
    always_comb begin
        if ((count_r != {CW{1'b0}}) && (count_r < FULL_COUNT) && !capture_s &&
            (idle_cnt_r == TW'(TIMEOUT_CYCLES - 1))) begin
            timeout_hit_s = 1'b1;
        end else begin
            timeout_hit_s = 1'b0;
        end
    end

    // Idle clock counter, running only while a packet is partially received.
    always_ff @(posedge clk_50m) begin
        if (rst) begin
            idle_cnt_r <= {TW{1'b0}};
        end else if (capture_s || timeout_hit_s || (count_r == {CW{1'b0}})) begin
            idle_cnt_r <= {TW{1'b0}};
        end else if (count_r < FULL_COUNT) begin
            idle_cnt_r <= idle_cnt_r + {{(TW-1){1'b0}}, 1'b1};
        end else begin
            idle_cnt_r <= idle_cnt_r;
        end
    end
`else
    // Without the timeout feature a partial packet simply waits for more bytes.
    always_comb begin
        timeout_hit_s = 1'b0;
    end
`endif

    // RX state, byte assembly, shadowed work word and registered RX strobes.
    always_ff @(posedge clk_50m) begin
        if (rst) begin
            rx_state_r   <= RX_IDLE;
            count_r      <= {CW{1'b0}};
            asm_r        <= {WW{1'b0}};
            work_data_r  <= {WW{1'b0}};
            work_valid_r <= 1'b0;
            rx_rdy_clr_r <= 1'b0;
            rx_timeout_r <= 1'b0;
        end else begin
            rx_state_r   <= rx_state_s;
            rx_rdy_clr_r <= capture_s;
            work_valid_r <= pkt_done_s;
            rx_timeout_r <= timeout_hit_s;
            if (capture_s) begin
                asm_r   <= {asm_r[WW-9:0], bus.rx_data};
                count_r <= count_r + {{(CW-1){1'b0}}, 1'b1};
            end else if (pkt_done_s) begin
                count_r     <= {CW{1'b0}};
                work_data_r <= asm_r;
            end else if (timeout_hit_s) begin
                count_r <= {CW{1'b0}};
            end else begin
                count_r <= count_r;
            end
        end
    end

    // TX next state: load a byte when the UART is free, see it accepted, see it finish.
    always_comb begin
        tx_state_s = tx_state_r;
        latch_s    = 1'b0;
        emit_s     = 1'b0;
        advance_s  = 1'b0;
        if (bus.nonce_valid && (tx_state_r != TX_IDLE)) begin
            drop_s = 1'b1;
        end else begin
            drop_s = 1'b0;
        end
        case (tx_state_r)
            TX_IDLE: begin
                if (bus.nonce_valid) begin
                    latch_s    = 1'b1;
                    tx_state_s = TX_LOAD;
                end else begin
                    tx_state_s = TX_IDLE;
                end
            end
            TX_LOAD: begin
                if (!bus.tx_busy) begin
                    emit_s     = 1'b1;
                    tx_state_s = TX_START;
                end else begin
                    tx_state_s = TX_LOAD;
                end
            end
            TX_START: begin
                if (bus.tx_busy) begin
                    tx_state_s = TX_BUSY;
                end else begin
                    tx_state_s = TX_START;
                end
            end
            TX_BUSY: begin
                if (!bus.tx_busy) begin
                    if (idx_r != 2'd3) begin
                        advance_s  = 1'b1;
                        tx_state_s = TX_LOAD;
                    end else begin
                        tx_state_s = TX_IDLE;
                    end
                end else begin
                    tx_state_s = TX_BUSY;
                end
            end
            default: tx_state_s = TX_IDLE;
        endcase
    end

    // TX state, latched nonce, byte index and registered UART write strobe.
    always_ff @(posedge clk_50m) begin
        if (rst) begin
            tx_state_r   <= TX_IDLE;
            nonce_r      <= 32'h0000_0000;
            idx_r        <= 2'd0;
            tx_din_r     <= 8'h00;
            tx_wr_en_r   <= 1'b0;
            nonce_drop_r <= 1'b0;
        end else begin
            tx_state_r   <= tx_state_s;
            tx_wr_en_r   <= emit_s;
            nonce_drop_r <= drop_s;
            if (latch_s) begin
                nonce_r <= bus.nonce;
                idx_r   <= 2'd0;
            end else if (advance_s) begin
                idx_r <= idx_r + 2'd1;
            end else begin
                idx_r <= idx_r;
            end
            if (emit_s) begin
                tx_din_r <= nonce_byte(nonce_r, idx_r);
            end else begin
                tx_din_r <= tx_din_r;
            end
        end
    end
endmodule

// File: tb/tb_uart_work_controller.sv
// Bench for uart_work_controller: behavioural UART on both sides, a byte-level
// model of packet assembly, and scoreboards for work words and transmitted bytes.
module tb_uart_work_controller;
    localparam int WB = 44;
    localparam int TO = 100;

    typedef struct {
        logic [31:0] nonce;
        logic [7:0]  b0, b1, b2, b3;
    } nonce_vec_t;

    typedef struct {
        logic [7:0] base;
        logic [7:0] step;
        logic [7:0] first;
        logic [7:0] last;
    } pkt_vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    uart_work_controller_if #(.WORK_BYTES(WB)) bus();

    uart_work_controller #(.WORK_BYTES(WB), .TIMEOUT_CYCLES(TO)) dut (
        .clk_50m (clk),
        .rst     (rst),
        .bus     (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int clr_cnt = 0, wv_cnt = 0, txb_cnt = 0, drop_cnt = 0, to_cnt = 0;
    logic [WB*8-1:0] work_q[$];
    logic [7:0]      tx_q[$];
    logic [WB*8-1:0] model_asm = '0;
    logic [WB*8-1:0] last_pkt = '0;
    int              model_cnt = 0;

    task automatic check(input string name, input logic [WB*8-1:0] act, input logic [WB*8-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Output monitors and scoreboard consumers, sampled on the inactive edge.
    initial begin
        forever begin
            @(negedge clk);
            if (bus.rx_rdy_clr) clr_cnt++;
            if (bus.nonce_drop) drop_cnt++;
            if (bus.rx_timeout) to_cnt++;
            if (bus.work_valid) begin
                wv_cnt++;
                check("work_expected", work_q.size() != 0, 1);
                if (work_q.size() != 0) check("work_data", bus.work_data, work_q.pop_front());
            end
            if (bus.tx_wr_en) begin
                txb_cnt++;
                check("tx_expected", tx_q.size() != 0, 1);
                if (tx_q.size() != 0) check("tx_din", bus.tx_din, tx_q.pop_front());
            end
        end
    end

    // UART transmitter model: busy for 6 cycles after each write strobe.
    initial begin
        bus.tx_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.tx_wr_en) begin
                bus.tx_busy = 1'b1;
                repeat (6) @(negedge clk);
                bus.tx_busy = 1'b0;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic send_byte(input logic [7:0] b);
        logic got;
        model_asm = {model_asm[WB*8-9:0], b};
        model_cnt++;
        if (model_cnt == WB) begin
            work_q.push_back(model_asm);
            last_pkt  = model_asm;
            model_cnt = 0;
        end
        @(negedge clk);
        bus.rx_data = b;
        bus.rx_rdy  = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (bus.rx_rdy_clr) got = 1'b1;
        end
        bus.rx_rdy = 1'b0;
        check("rx_ack_seen", got, 1);
        repeat (2) @(negedge clk);
    endtask

    task automatic send_bytes(input logic [7:0] base, input logic [7:0] step, input int n);
        logic [7:0] v;
        v = base;
        for (int i = 0; i < n; i++) begin
            send_byte(v);
            v = v + step;
        end
    endtask

    task automatic pulse_nonce(input logic [31:0] n);
        @(negedge clk);
        bus.nonce       = n;
        bus.nonce_valid = 1'b1;
        @(negedge clk);
        bus.nonce_valid = 1'b0;
    endtask

    task automatic wait_tx(input int target);
        for (int i = 0; i < 400 && txb_cnt < target; i++) @(negedge clk);
        check("tx_byte_count", txb_cnt, target);
    endtask

    nonce_vec_t nvec[4];
    pkt_vec_t   pvec[4];

    initial begin
        int c0, w0, t0, d0, o0;
        logic [WB*8-1:0] prev;
        logic [7:0] b;

        nvec[0] = '{32'hDEADBEEF, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
        nvec[1] = '{32'h12345678, 8'h12, 8'h34, 8'h56, 8'h78};
        nvec[2] = '{32'h00000000, 8'h00, 8'h00, 8'h00, 8'h00};
        nvec[3] = '{32'hA5C30F81, 8'hA5, 8'hC3, 8'h0F, 8'h81};
        pvec[0] = '{8'h00, 8'h01, 8'h00, 8'h2B};
        pvec[1] = '{8'h80, 8'h01, 8'h80, 8'hAB};
        pvec[2] = '{8'hFF, 8'hFF, 8'hFF, 8'hD4};
        pvec[3] = '{8'h5A, 8'h00, 8'h5A, 8'h5A};

        bus.rx_rdy = 1'b0; bus.rx_data = 8'h00;
        bus.nonce = 32'h0; bus.nonce_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_rx_rdy_clr", bus.rx_rdy_clr, 0);
        check("rst_work_valid", bus.work_valid, 0);
        check("rst_work_data", bus.work_data, 0);
        check("rst_tx_wr_en", bus.tx_wr_en, 0);
        check("rst_tx_din", bus.tx_din, 0);
        check("rst_nonce_drop", bus.nonce_drop, 0);
        check("rst_rx_timeout", bus.rx_timeout, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Packets: 44 acks, one work_valid, shadow word stable while the next arrives.
        for (int k = 0; k < 4; k++) begin
            c0 = clr_cnt; w0 = wv_cnt; prev = last_pkt; b = pvec[k].base;
            for (int i = 0; i < WB; i++) begin
                if (i == 1 || i == WB - 1) check("work_data_stable", bus.work_data, prev);
                send_byte(b);
                b = b + pvec[k].step;
            end
            repeat (4) @(negedge clk);
            check("rdy_clr_pulses", clr_cnt - c0, WB);
            check("work_valid_pulses", wv_cnt - w0, 1);
            check("work_first_byte", bus.work_data[WB*8-1 -: 8], pvec[k].first);
            check("work_last_byte", bus.work_data[7:0], pvec[k].last);
        end

        // Nonces: 4 bytes MSB first, no drop, TX idle again afterwards.
        for (int k = 0; k < 4; k++) begin
            t0 = txb_cnt; d0 = drop_cnt;
            tx_q.push_back(nvec[k].b0); tx_q.push_back(nvec[k].b1);
            tx_q.push_back(nvec[k].b2); tx_q.push_back(nvec[k].b3);
            pulse_nonce(nvec[k].nonce);
            wait_tx(t0 + 4);
            repeat (8) @(negedge clk);
            check("no_drop", drop_cnt - d0, 0);
        end

        // Second nonce while the first is mid-flight is dropped for one cycle.
        t0 = txb_cnt; d0 = drop_cnt;
        tx_q.push_back(8'hDE); tx_q.push_back(8'hAD); tx_q.push_back(8'hBE); tx_q.push_back(8'hEF);
        pulse_nonce(32'hDEADBEEF);
        wait_tx(t0 + 2);
        pulse_nonce(32'h12345678);
        repeat (2) @(negedge clk);
        check("drop_pulse", drop_cnt - d0, 1);
        wait_tx(t0 + 4);
        repeat (50) @(negedge clk);
        check("tx_bytes_after_drop", txb_cnt - t0, 4);

        // Simultaneous packet reception and nonce transmission.
        t0 = txb_cnt; w0 = wv_cnt;
        tx_q.push_back(8'hCA); tx_q.push_back(8'hFE); tx_q.push_back(8'hF0); tx_q.push_back(8'h0D);
        fork
            send_bytes(8'h40, 8'h03, WB);
            pulse_nonce(32'hCAFEF00D);
        join
        wait_tx(t0 + 4);
        repeat (10) @(negedge clk);
        check("concurrent_work_valid", wv_cnt - w0, 1);

        // Reset after 20 rx bytes and during the first byte of a nonce.
        send_bytes(8'h20, 8'h01, 20);
        t0 = txb_cnt; w0 = wv_cnt;
        tx_q.push_back(8'h11); tx_q.push_back(8'h22); tx_q.push_back(8'h33); tx_q.push_back(8'h44);
        pulse_nonce(32'h11223344);
        wait_tx(t0 + 1);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_work_data", bus.work_data, 0);
        check("mid_rst_tx_wr_en", bus.tx_wr_en, 0);
        check("mid_rst_tx_din", bus.tx_din, 0);
        check("mid_rst_work_valid", bus.work_valid, 0);
        check("mid_rst_rx_rdy_clr", bus.rx_rdy_clr, 0);
        rst = 1'b0;
        tx_q.delete();
        model_cnt = 0;
        last_pkt  = '0;
        repeat (60) @(negedge clk);
        check("no_tx_after_rst", txb_cnt - t0, 1);
        send_bytes(8'h00, 8'h01, WB);
        repeat (4) @(negedge clk);
        check("post_rst_packet", wv_cnt - w0, 1);
        check("post_rst_first", bus.work_data[WB*8-1 -: 8], 8'h00);

        // Partial packet followed by a long idle gap.
        w0 = wv_cnt; o0 = to_cnt; prev = last_pkt;
        send_bytes(8'hC0, 8'h01, 10);
        repeat (TO + 50) @(negedge clk);
        check("idle_no_work_valid", wv_cnt - w0, 0);
        check("idle_work_data", bus.work_data, prev);
`ifdef UART_CTRL_TIMEOUT_EN
        check("timeout_pulses", to_cnt - o0, 1);
        model_cnt = 0;
        send_bytes(8'h10, 8'h01, WB);
`else
        check("timeout_pulses", to_cnt - o0, 0);
        send_bytes(8'hCA, 8'h01, WB - 10);
`endif
        repeat (4) @(negedge clk);
        check("after_idle_packet", wv_cnt - w0, 1);
        check("scoreboard_drained", work_q.size() + tx_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
